flash_pin_arbiter: RTL and testbench

FLASH_PIN_ARBITER -- requirements
Module: flash_pin_arbiter

---
 rtl/flash_arb_pkg.sv | 32 +++
 rtl/flash_pin_arbiter_if.sv | 56 +++++
 rtl/flash_arb_pinmux.sv | 56 +++++
 rtl/flash_pin_arbiter.sv | 145 ++++++++++++++
 tb/tb_flash_pin_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/flash_arb_pkg.sv
// Shared constants for the flash pin arbiter: FSM state codes, owner encoding, idle pin levels.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package flash_arb_pkg;

  // FSM state codes, kept as plain vectors so legacy tools can consume them
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_GNT_SPI  = 3'd1;
  localparam state_t ST_GNT_QSPI = 3'd2;
  localparam state_t ST_DRAIN    = 3'd3;
  localparam state_t ST_TURN     = 3'd4;

  // Owner encoding, also driven out on oOWNER
  typedef logic [1:0] owner_t;
  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_SPI  = 2'b01;
  localparam owner_t OWN_QSPI = 2'b10;

  // Parked pins: HOLD/WP driven high, DQ1/DQ0 released
  localparam logic [3:0] IDLE_DQ_OUT = 4'b1100;
  localparam logic [3:0] IDLE_DQ_OE  = 4'b1100;

  // Legacy SPI drives HOLD, WP and MOSI; DQ1 is MISO so it stays an input
  localparam logic [3:0] SPI_DQ_OE = 4'b1101;

  // Legacy SPI output word: HOLD=1, WP=1, DQ1 parked low, MOSI on DQ0
  function automatic logic [3:0] spi_dq_out(input logic mosi);
    return {3'b110, mosi};
  endfunction

endpackage

// File: rtl/flash_pin_arbiter_if.sv
// Bundle of request/grant, master-side pins, flash-side pins and status for the arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; ownership is negotiated by the REQ/GNT pairs carried here.
interface flash_pin_arbiter_if;

  // legacy SPI master (owner 0)
  logic       iSPI_REQ;
  logic       oSPI_GNT;
  logic       iSPI_CSn;
  logic       iSPI_SCK;
  logic       iSPI_MOSI;
  logic       oSPI_MISO;

  // QSPI controller (owner 1)
  logic       iQSPI_REQ;
  logic       oQSPI_GNT;
  logic       iQSPI_NCS;
  logic       iQSPI_DCLK;
  logic [3:0] iQSPI_DATAOUT;
  logic [3:0] iQSPI_DATAOE;
  logic [3:0] oQSPI_DATAIN;

  // shared flash pins (tristate buffers sit outside the arbiter)
  logic       oFLASH_CS;
  logic       oFLASH_SCK;
  logic [3:0] oFLASH_DQ_OUT;
  logic [3:0] oFLASH_DQ_OE;
  logic [3:0] iFLASH_DQ_IN;

  // status
  logic [1:0] oOWNER;
  logic       oBUSY;
  logic       oERR;
  logic       iERR_CLR;

  // arbiter side
  modport slave (
    input  iSPI_REQ, iSPI_CSn, iSPI_SCK, iSPI_MOSI,
    input  iQSPI_REQ, iQSPI_NCS, iQSPI_DCLK, iQSPI_DATAOUT, iQSPI_DATAOE,
    input  iFLASH_DQ_IN, iERR_CLR,
    output oSPI_GNT, oSPI_MISO, oQSPI_GNT, oQSPI_DATAIN,
    output oFLASH_CS, oFLASH_SCK, oFLASH_DQ_OUT, oFLASH_DQ_OE,
    output oOWNER, oBUSY, oERR
  );

  // requester / board side
  modport master (
    output iSPI_REQ, iSPI_CSn, iSPI_SCK, iSPI_MOSI,
    output iQSPI_REQ, iQSPI_NCS, iQSPI_DCLK, iQSPI_DATAOUT, iQSPI_DATAOE,
    output iFLASH_DQ_IN, iERR_CLR,
    input  oSPI_GNT, oSPI_MISO, oQSPI_GNT, oQSPI_DATAIN,
    input  oFLASH_CS, oFLASH_SCK, oFLASH_DQ_OUT, oFLASH_DQ_OE,
    input  oOWNER, oBUSY, oERR
  );

endinterface

// File: rtl/flash_arb_pinmux.sv
// Steers the selected owner's pins onto the flash; parks the pins when nobody owns them.
// Latency: purely combinational from the registered owner select.
// Backpressure: none; the non-selected master's pins are simply not observed.
module flash_arb_pinmux
  import flash_arb_pkg::*;
(
  input  owner_t     i_owner,
  input  logic       i_spi_csn,
  input  logic       i_spi_sck,
  input  logic       i_spi_mosi,
  input  logic       i_qspi_ncs,
  input  logic       i_qspi_dclk,
  input  logic [3:0] i_qspi_dataout,
  input  logic [3:0] i_qspi_dataoe,
  input  logic [3:0] i_flash_dq_in,
  output logic       o_flash_cs,
  output logic       o_flash_sck,
  output logic [3:0] o_flash_dq_out,
  output logic [3:0] o_flash_dq_oe,
  output logic       o_spi_miso,
  output logic [3:0] o_qspi_datain
);

  // Read data fans out to both masters unconditionally; only the owner acts on it
  assign o_spi_miso    = i_flash_dq_in[1];
  assign o_qspi_datain = i_flash_dq_in;

  // Output mux: owner's pins when selected, otherwise the parked pattern
  always_comb begin
    o_flash_cs     = 1'b1;
    o_flash_sck    = 1'b0;
    o_flash_dq_out = IDLE_DQ_OUT;
    o_flash_dq_oe  = IDLE_DQ_OE;
    case (i_owner)
      OWN_SPI: begin
        o_flash_cs     = i_spi_csn;
        o_flash_sck    = i_spi_sck;
        o_flash_dq_out = spi_dq_out(i_spi_mosi);
        o_flash_dq_oe  = SPI_DQ_OE;
      end
      OWN_QSPI: begin
        o_flash_cs     = i_qspi_ncs;
        o_flash_sck    = i_qspi_dclk;
        o_flash_dq_out = i_qspi_dataout;
        o_flash_dq_oe  = i_qspi_dataoe;
      end
      default: begin
        o_flash_cs     = 1'b1;
        o_flash_sck    = 1'b0;
        o_flash_dq_out = IDLE_DQ_OUT;
        o_flash_dq_oe  = IDLE_DQ_OE;
      end
    endcase
  end

endmodule

// File: rtl/flash_pin_arbiter.sv
// Round-robin arbiter sharing one SPI flash between a legacy SPI master and a QSPI controller.
// Latency: grant 1 cycle after REQ is sampled in IDLE; pins follow the owner combinationally.
// Backpressure: a requester waits with REQ high until GNT; release drains CS then idles pTURN cycles.
module flash_pin_arbiter
  import flash_arb_pkg::*;
#(
  parameter int pTURN    = 2,
  parameter int pTIMEOUT = 1024
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  flash_pin_arbiter_if.slave   bus
);

  localparam int                LP_CW         = $clog2(pTIMEOUT);
  localparam logic [LP_CW-1:0]  LP_DRAIN_LAST = LP_CW'(pTIMEOUT - 1);
  localparam logic [3:0]        LP_TURN_LAST  = 4'(pTURN - 1);

  state_t           r_state;
  owner_t           r_owner;
  logic             r_last_qspi;   // 1: QSPI was granted most recently
  logic [LP_CW-1:0] r_drain_cnt;
  logic [3:0]       r_turn_cnt;
  logic             r_err;

  state_t           w_state_nxt;
  owner_t           w_owner_nxt;
  logic             w_last_nxt;
  logic [LP_CW-1:0] w_drain_nxt;
  logic [3:0]       w_turn_nxt;
  logic             w_err_set;
  logic             w_owner_req;
  logic             w_owner_csn;

  // REQ and CS of whoever currently holds the pins
  assign w_owner_req = (r_owner == OWN_SPI) ? bus.iSPI_REQ : bus.iQSPI_REQ;
  assign w_owner_csn = (r_owner == OWN_SPI) ? bus.iSPI_CSn : bus.iQSPI_NCS;

  // Next-state: arbitration in IDLE, release detection, CS drain with timeout, turnaround
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_qspi;
    w_drain_nxt = r_drain_cnt;
    w_turn_nxt  = r_turn_cnt;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // On contention the side not granted last wins
        if (bus.iQSPI_REQ && (!bus.iSPI_REQ || !r_last_qspi)) begin
          w_state_nxt = ST_GNT_QSPI;
          w_owner_nxt = OWN_QSPI;
          w_last_nxt  = 1'b1;
        end else if (bus.iSPI_REQ) begin
          w_state_nxt = ST_GNT_SPI;
          w_owner_nxt = OWN_SPI;
          w_last_nxt  = 1'b0;
        end
      end
      ST_GNT_SPI, ST_GNT_QSPI: begin
        if (!w_owner_req) begin
          if (w_owner_csn) begin
            w_state_nxt = ST_TURN;
            w_owner_nxt = OWN_NONE;
            w_turn_nxt  = '0;
          end else begin
            // Owner let go mid-transaction: keep its pins until CS rises
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (w_owner_csn) begin
          w_state_nxt = ST_TURN;
          w_owner_nxt = OWN_NONE;
          w_turn_nxt  = '0;
        end else if (r_drain_cnt == LP_DRAIN_LAST) begin
          w_state_nxt = ST_TURN;
          w_owner_nxt = OWN_NONE;
          w_turn_nxt  = '0;
          w_err_set   = 1'b1;
        end else begin
          w_drain_nxt = r_drain_cnt + 1'b1;
        end
      end
      ST_TURN: begin
        if (r_turn_cnt == LP_TURN_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_turn_nxt = r_turn_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // State registers; reset aborts any grant/drain straight to IDLE with no turnaround
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_NONE;
      r_last_qspi <= 1'b0;
      r_drain_cnt <= '0;
      r_turn_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last_qspi <= w_last_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_turn_cnt  <= w_turn_nxt;
      // A new forced release wins over a simultaneous clear
      r_err       <= w_err_set | (r_err & ~bus.iERR_CLR);
    end
  end

  assign bus.oSPI_GNT  = (r_state == ST_GNT_SPI);
  assign bus.oQSPI_GNT = (r_state == ST_GNT_QSPI);
  assign bus.oOWNER    = r_owner;
  assign bus.oBUSY     = (r_state != ST_IDLE);
  assign bus.oERR      = r_err;

  flash_arb_pinmux u_pinmux (
    .i_owner        (r_owner),
    .i_spi_csn      (bus.iSPI_CSn),
    .i_spi_sck      (bus.iSPI_SCK),
    .i_spi_mosi     (bus.iSPI_MOSI),
    .i_qspi_ncs     (bus.iQSPI_NCS),
    .i_qspi_dclk    (bus.iQSPI_DCLK),
    .i_qspi_dataout (bus.iQSPI_DATAOUT),
    .i_qspi_dataoe  (bus.iQSPI_DATAOE),
    .i_flash_dq_in  (bus.iFLASH_DQ_IN),
    .o_flash_cs     (bus.oFLASH_CS),
    .o_flash_sck    (bus.oFLASH_SCK),
    .o_flash_dq_out (bus.oFLASH_DQ_OUT),
    .o_flash_dq_oe  (bus.oFLASH_DQ_OE),
    .o_spi_miso     (bus.oSPI_MISO),
    .o_qspi_datain  (bus.oQSPI_DATAIN)
  );

endmodule

// File: tb/tb_flash_pin_arbiter.sv
// Directed bench for flash_pin_arbiter (pTURN=2, pTIMEOUT=16).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-derived per step.
module tb_flash_pin_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  flash_pin_arbiter_if bus();

  flash_pin_arbiter #(.pTURN(2), .pTIMEOUT(16)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {SPI_GNT, QSPI_GNT, OWNER[1:0], BUSY, ERR}
  task automatic chk_stat(input string tag, input logic sg, input logic qg,
                          input logic [1:0] own, input logic busy, input logic err);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {bus.oSPI_GNT, bus.oQSPI_GNT, bus.oOWNER, bus.oBUSY, bus.oERR};
    exp = {sg, qg, own, busy, err};
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s gnt_s/gnt_q/owner/busy/err observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {CS, SCK, DQ_OUT, DQ_OE}
  task automatic chk_pins(input string tag, input logic cs, input logic sck,
                          input logic [3:0] dqo, input logic [3:0] dqe);
    logic [9:0] obs;
    logic [9:0] exp;
    obs = {bus.oFLASH_CS, bus.oFLASH_SCK, bus.oFLASH_DQ_OUT, bus.oFLASH_DQ_OE};
    exp = {cs, sck, dqo, dqe};
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cs/sck/dq_out/dq_oe observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // {SPI_MISO, QSPI_DATAIN}
  task automatic chk_rd(input string tag, input logic miso, input logic [3:0] din);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {bus.oSPI_MISO, bus.oQSPI_DATAIN};
    exp = {miso, din};
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s miso/datain observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b1;
    bus.iSPI_REQ      = 1'b0;
    bus.iSPI_CSn      = 1'b1;
    bus.iSPI_SCK      = 1'b0;
    bus.iSPI_MOSI     = 1'b0;
    bus.iQSPI_REQ     = 1'b0;
    bus.iQSPI_NCS     = 1'b1;
    bus.iQSPI_DCLK    = 1'b0;
    bus.iQSPI_DATAOUT = 4'h0;
    bus.iQSPI_DATAOE  = 4'h0;
    bus.iFLASH_DQ_IN  = 4'hA;
    bus.iERR_CLR      = 1'b0;

    // ---- reset state
    step(); step();
    chk_stat("reset_stat", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk_pins("reset_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    rst = 1'b0;
    step();
    chk_stat("idle_stat", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // ---- read data always fans out
    chk_rd("rd_a", 1'b1, 4'hA);
    bus.iFLASH_DQ_IN = 4'h5; #1;
    chk_rd("rd_5", 1'b0, 4'h5);

    // ---- nobody owns the pins: inputs must not leak
    bus.iSPI_SCK = 1'b1; bus.iQSPI_DCLK = 1'b1; bus.iSPI_CSn = 1'b0; bus.iQSPI_NCS = 1'b0; #1;
    chk_pins("idle_isolation", 1'b1, 1'b0, 4'hC, 4'hC);
    bus.iSPI_SCK = 1'b0; bus.iQSPI_DCLK = 1'b0; bus.iSPI_CSn = 1'b1; bus.iQSPI_NCS = 1'b1;

    // ---- SPI alone: grant after one edge, SPI pin mapping
    bus.iSPI_REQ = 1'b1;
    step();
    chk_stat("spi_grant", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    bus.iSPI_MOSI = 1'b1; #1;
    chk_pins("spi_mosi1", 1'b1, 1'b0, 4'hD, 4'hD);
    bus.iSPI_MOSI = 1'b0; bus.iSPI_CSn = 1'b0; bus.iSPI_SCK = 1'b1; #1;
    chk_pins("spi_mosi0", 1'b0, 1'b1, 4'hC, 4'hD);
    bus.iSPI_CSn = 1'b1; bus.iSPI_SCK = 1'b0;
    bus.iQSPI_NCS = 1'b0; bus.iQSPI_DCLK = 1'b1; bus.iQSPI_DATAOUT = 4'hF; bus.iQSPI_DATAOE = 4'hF; #1;
    chk_pins("spi_isolation", 1'b1, 1'b0, 4'hC, 4'hD);
    bus.iQSPI_NCS = 1'b1; bus.iQSPI_DCLK = 1'b0; bus.iQSPI_DATAOUT = 4'h0; bus.iQSPI_DATAOE = 4'h0;

    // ---- SPI release with CS high: TURN x2 then IDLE
    bus.iSPI_REQ = 1'b0;
    step();
    chk_stat("spi_rel_turn1", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk_pins("spi_rel_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    step();
    chk_stat("spi_rel_turn2", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step();
    chk_stat("spi_rel_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // ---- both request after reset: QSPI first
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.iSPI_REQ = 1'b1; bus.iQSPI_REQ = 1'b1;
    step();
    chk_stat("rr_qspi_first", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    bus.iQSPI_NCS = 1'b0; bus.iQSPI_DCLK = 1'b1; bus.iQSPI_DATAOUT = 4'h9; bus.iQSPI_DATAOE = 4'hF;
    bus.iSPI_MOSI = 1'b1; #1;
    chk_pins("qspi_map", 1'b0, 1'b1, 4'h9, 4'hF);
    bus.iQSPI_DCLK = 1'b0; bus.iSPI_SCK = 1'b1; #1;
    chk_pins("qspi_isolation", 1'b0, 1'b0, 4'h9, 4'hF);
    bus.iSPI_SCK = 1'b0; bus.iSPI_MOSI = 1'b0;

    // QSPI drops REQ with NCS high: two idle-pin cycles, IDLE, then SPI
    bus.iQSPI_NCS = 1'b1; bus.iQSPI_REQ = 1'b0;
    step();
    chk_stat("q_rel_turn1", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk_pins("q_rel_turn1_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    bus.iQSPI_REQ = 1'b1;   // not looked at during TURN
    step();
    chk_stat("q_rel_turn2", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk_pins("q_rel_turn2_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    step();
    chk_stat("q_rel_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk_stat("rr_spi_second", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);

    // SPI releases while QSPI waits; SPI asks again during TURN -> QSPI wins
    bus.iSPI_REQ = 1'b0;
    step();
    bus.iSPI_REQ = 1'b1;
    step();
    step();
    chk_stat("rr_idle_again", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    chk_stat("rr_qspi_third", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);

    // ---- QSPI drain: REQ low with NCS low, NCS rises after 10 DRAIN cycles
    bus.iSPI_REQ = 1'b0;
    bus.iQSPI_NCS = 1'b0; bus.iQSPI_REQ = 1'b0;
    step();
    chk_stat("drain_1", 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    chk_pins("drain_follow", 1'b0, 1'b0, 4'h9, 4'hF);
    for (int i = 2; i <= 10; i++) begin
      if (i == 5) bus.iQSPI_REQ = 1'b1;   // reassert during DRAIN is ignored
      if (i == 7) bus.iQSPI_REQ = 1'b0;
      step();
      chk_stat($sformatf("drain_%0d", i), 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    end
    bus.iQSPI_NCS = 1'b1;
    step();
    chk_stat("drain_exit_turn", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk_pins("drain_exit_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    step();
    step();
    chk_stat("drain_idle_no_err", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // ---- SPI timeout: CSn held low, forced release after 16 DRAIN cycles
    bus.iSPI_CSn = 1'b0; bus.iSPI_REQ = 1'b1;
    step();
    chk_stat("to_grant", 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
    bus.iSPI_REQ = 1'b0;
    step();
    chk_stat("to_drain_1", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk_stat($sformatf("to_drain_%0d", i), 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    end
    step();
    chk_stat("to_forced_turn", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    chk_pins("to_forced_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    bus.iERR_CLR = 1'b1;
    step();
    chk_stat("err_cleared", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    step();
    chk_stat("to_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // ---- second timeout with clear held high: set wins over clear
    bus.iSPI_REQ = 1'b1;
    step();
    bus.iSPI_REQ = 1'b0;
    step();
    chk_stat("to2_drain_1", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    repeat (15) step();
    chk_stat("to2_drain_16", 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    step();
    chk_stat("err_set_beats_clr", 1'b0, 1'b0, 2'b00, 1'b1, 1'b1);
    step();
    chk_stat("err_clr_after", 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    bus.iERR_CLR = 1'b0;
    bus.iSPI_CSn = 1'b1;
    step();
    chk_stat("to2_idle", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    // ---- reset during GNT_QSPI with NCS low
    bus.iQSPI_NCS = 1'b0; bus.iQSPI_REQ = 1'b1;
    step();
    chk_stat("rst_pre_grant", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);
    chk_pins("rst_pre_pins", 1'b0, 1'b0, 4'h9, 4'hF);
    rst = 1'b1;
    step();
    chk_stat("rst_mid_grant", 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk_pins("rst_mid_pins", 1'b1, 1'b0, 4'hC, 4'hC);
    rst = 1'b0;
    step();
    chk_stat("rst_regrant_no_turn", 1'b0, 1'b1, 2'b10, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
